// File: rtl/xor_stream_cipher_nch.sv
// Multi-channel XOR stream cipher: CH independent Galois-LFSR keystreams, a serial
// configuration chain holding per-channel {taps, seed}, and optional periodic rekey.
module xor_stream_cipher_nch #(
  parameter int           N            = 48,
  parameter int           CH           = 2,
  parameter logic [N-1:0] TAPS_DEFAULT = 48'h000048000000,
  parameter logic [N-1:0] SEED_DEFAULT = 48'h000000000055,
  parameter int           REKEY_PERIOD = 0,
  parameter int           HB_LSB       = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_en,
  input  logic          cfg_i,
  output logic          cfg_o,
  input  logic [CH-1:0] ch_en,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  output logic [CH-1:0] dout_valid,
  output logic          busy,
  output logic [2:0]    heartbeat
);

  localparam int CW = CH * 2 * N;
  localparam logic [CW-1:0] CFG_DEFAULT = {CH{TAPS_DEFAULT, SEED_DEFAULT}};

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_CFG  = 2'd1,
    S_LOAD = 2'd2
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cfg_reg;
  logic [CH-1:0][N-1:0]    lfsr;
  logic [CH-1:0][N-1:0]    taps;
  logic [CH-1:0][N-1:0]    seed_eff;
  logic [CH-1:0][N-1:0]    lfsr_step;
  logic [CH-1:0]           advance;
  logic [CH-1:0]           rekey_hit;
  logic [15:0]             hb_cnt;

  // Per-channel key fields and next-state candidates. A zero seed would lock the
  // LFSR at zero forever, so it is replaced by 1 whenever a seed is loaded.
  // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    taps      = '0;
    seed_eff  = '0;
    lfsr_step = '0;
    advance   = '0;
    for (int c = 0; c < CH; c++) begin
      taps[c]      = cfg_reg[c*2*N+N +: N];
      seed_eff[c]  = (cfg_reg[c*2*N +: N] == '0) ? N'(1) : cfg_reg[c*2*N +: N];
      lfsr_step[c] = {1'b0, lfsr[c][N-1:1]} ^ (lfsr[c][0] ? taps[c] : '0);
      advance[c]   = (state == S_RUN) && !cfg_en && ch_en[c];
    end
  end

  generate
    if (REKEY_PERIOD > 0) begin : g_rekey
      localparam int RKW = $clog2(REKEY_PERIOD + 1);
      logic [CH-1:0][RKW-1:0] rk_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rk_cnt <= '0;
        end else begin
          for (int c = 0; c < CH; c++) begin
            if (state == S_LOAD)
              rk_cnt[c] <= '0;
            else if (advance[c])
              rk_cnt[c] <= rekey_hit[c] ? '0 : rk_cnt[c] + RKW'(1);
          end
        end
      end

      always_comb begin
        rekey_hit = '0;
        for (int c = 0; c < CH; c++)
          rekey_hit[c] = (rk_cnt[c] == RKW'(REKEY_PERIOD - 1));
      end
    end else begin : g_no_rekey
      assign rekey_hit = '0;
    end
  endgenerate

  // Control FSM and channel datapath share one block so that configuration
  // always takes priority over channel enables on the same edge.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the small LFSR/config arrays are flops, not RAM, so they take the async reset directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RUN;
      cfg_reg    <= CFG_DEFAULT;
      lfsr       <= {CH{SEED_DEFAULT}};
      dout       <= '0;
      dout_valid <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (cfg_en) begin
            state      <= S_CFG;
            cfg_reg    <= {cfg_i, cfg_reg[CW-1:1]};
            dout       <= '0;
            dout_valid <= '0;
          end else begin
            for (int c = 0; c < CH; c++) begin
              if (ch_en[c]) begin
                dout[c]       <= din[c] ^ lfsr[c][0];
                dout_valid[c] <= 1'b1;
                lfsr[c]       <= rekey_hit[c] ? seed_eff[c] : lfsr_step[c];
              end else begin
                dout_valid[c] <= 1'b0;
              end
            end
          end
        end
        S_CFG: begin
          dout       <= '0;
          dout_valid <= '0;
          if (cfg_en)
            cfg_reg <= {cfg_i, cfg_reg[CW-1:1]};
          else
            state <= S_LOAD;
        end
        S_LOAD: begin
          dout       <= '0;
          dout_valid <= '0;
          lfsr       <= seed_eff;
          state      <= S_RUN;
        end
        default: begin
          state <= S_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hb_cnt <= '0;
    else
      hb_cnt <= hb_cnt + 16'd1;
  end

  assign cfg_o     = (state == S_CFG) & cfg_reg[0];
  assign busy      = (state != S_RUN);
  assign heartbeat = hb_cnt[HB_LSB+2:HB_LSB];

endmodule
